// File: rtl/pll_reset_sequencer_if.sv
// Signal bundle between the PLL/reset sequencer and the PLL plus core-reset fabric.
// The sequencer uses the master view; the PLL side and the bench use the slave view.
interface pll_reset_sequencer_if;
   logic       pll_lock;
   logic       soft_rst;
   logic       pll_rst;
   logic       sys_rst_n;
   logic [1:0] state_o;
   logic [3:0] retries;

   modport master (
      input  pll_lock,
      input  soft_rst,
      output pll_rst,
      output sys_rst_n,
      output state_o,
      output retries
   );

   modport slave (
      output pll_lock,
      output soft_rst,
      input  pll_rst,
      input  sys_rst_n,
      input  state_o,
      input  retries
   );
endinterface

// File: rtl/pll_reset_sequencer.sv
// PLL reset pulse and core reset release sequencer, clocked by the free-running oscillator.
// Optional feature macro: PLL_WATCHDOG_EN (WAIT_LOCK timeout with PLL re-reset and retry count).
module pll_reset_sequencer #(
   parameter logic [15:0] LOCK_CYCLES    = 16'd1024,
   parameter logic [7:0]  PLL_RST_CYCLES = 8'd16,
   parameter logic [19:0] TIMEOUT_CYCLES = 20'd65536
) (
   input logic                   clock,
   input logic                   reset_n,
   pll_reset_sequencer_if.master bus
);

   typedef enum logic [1:0] {
      PLL_RST   = 2'd0,
      WAIT_LOCK = 2'd1,
      COUNT     = 2'd2,
      RUN       = 2'd3
   } state_t;

   localparam logic [19:0] RST_LAST  = {12'd0, PLL_RST_CYCLES} - 20'd1;
   localparam logic [19:0] LOCK_LAST = {4'd0, LOCK_CYCLES} - 20'd1;

   state_t      state_r;
   state_t      state_nxt_s;
   logic [19:0] cnt_r;
   logic [19:0] cnt_nxt_s;
   logic        lock_meta_r;
   logic        lock_sync_r;
   logic        pll_rst_r;
   logic        sys_rst_n_r;

`ifdef PLL_WATCHDOG_EN
   localparam logic [19:0] TIMEOUT_LAST = TIMEOUT_CYCLES - 20'd1;
   logic       retry_inc_s;
   logic [3:0] retries_r;
`else
   logic       unused_timeout_s;
`endif

   // Two-flop synchroniser for the asynchronous PLL LOCKED input.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         lock_meta_r <= 1'b0;
         lock_sync_r <= 1'b0;
      end else begin
         lock_meta_r <= bus.pll_lock;
         lock_sync_r <= lock_meta_r;
      end
   end

   // Next-state and shared-counter logic; soft_rst overrides every other transition.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
`ifdef PLL_WATCHDOG_EN
      retry_inc_s = 1'b0;
`endif
      if (bus.soft_rst) begin
         state_nxt_s = PLL_RST;
         cnt_nxt_s   = 20'd0;
      end else begin
         case (state_r)
            PLL_RST: begin
               if (cnt_r == RST_LAST) begin
                  state_nxt_s = WAIT_LOCK;
                  cnt_nxt_s   = 20'd0;
               end else begin
                  cnt_nxt_s = cnt_r + 20'd1;
               end
            end
            WAIT_LOCK: begin
               if (lock_sync_r) begin
                  state_nxt_s = COUNT;
                  cnt_nxt_s   = 20'd0;
               end else begin
`ifdef PLL_WATCHDOG_EN
                  if (cnt_r == TIMEOUT_LAST) begin
                     state_nxt_s = PLL_RST;
                     cnt_nxt_s   = 20'd0;
                     retry_inc_s = 1'b1;
                  end else begin
                     cnt_nxt_s = cnt_r + 20'd1;
                  end
`else
                  cnt_nxt_s = 20'd0;
`endif
               end
            end
            COUNT: begin
               // Any dropout restarts the stability count from zero.
               if (!lock_sync_r) begin
                  state_nxt_s = WAIT_LOCK;
                  cnt_nxt_s   = 20'd0;
               end else if (cnt_r == LOCK_LAST) begin
                  state_nxt_s = RUN;
                  cnt_nxt_s   = 20'd0;
               end else begin
                  cnt_nxt_s = cnt_r + 20'd1;
               end
            end
            RUN: begin
               // The PLL relocks on its own, so lock loss only re-asserts the core reset.
               if (!lock_sync_r) begin
                  state_nxt_s = WAIT_LOCK;
                  cnt_nxt_s   = 20'd0;
               end else begin
                  state_nxt_s = RUN;
               end
            end
            default: begin
               state_nxt_s = PLL_RST;
               cnt_nxt_s   = 20'd0;
            end
         endcase
      end
   end

   // State, counter and Moore output registers; outputs track the next state.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_r     <= PLL_RST;
         cnt_r       <= 20'd0;
         pll_rst_r   <= 1'b1;
         sys_rst_n_r <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         cnt_r       <= cnt_nxt_s;
         pll_rst_r   <= (state_nxt_s == PLL_RST);
         sys_rst_n_r <= (state_nxt_s == RUN);
      end
   end

`ifdef PLL_WATCHDOG_EN
   // Saturating count of watchdog-triggered PLL resets.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         retries_r <= 4'd0;
      end else if (retry_inc_s && (retries_r != 4'd15)) begin
         retries_r <= retries_r + 4'd1;
      end else begin
         retries_r <= retries_r;
      end
   end

   assign bus.retries = retries_r;
`else
   assign unused_timeout_s = ^TIMEOUT_CYCLES;
   assign bus.retries      = 4'd0;
`endif

   assign bus.pll_rst   = pll_rst_r;
   assign bus.sys_rst_n = sys_rst_n_r;
   assign bus.state_o   = state_r;

endmodule
